// File: rtl/bg_pkg.sv
// Shared definitions for background draw blocks.
// Holds the per-theme palette (struct of 12-bit colours and the 4-entry
// theme table), the packed VGA timing bundle used by delay lines, the
// colour-class enum passed between pipeline stages, and small helpers.
package bg_pkg;

    typedef struct packed {
        logic [11:0] wall_base;
        logic [11:0] mortar;
        logic [11:0] col_base;
        logic [11:0] col_dark;
        logic [11:0] win_hi;
        logic [11:0] win_lo;
        logic [11:0] win_glow;
        logic [11:0] floor_base;
        logic [11:0] floor_dark;
    } palette_t;

    localparam palette_t THEME_PALETTE [4] = '{
        '{12'h833, 12'h444, 12'h999, 12'h666, 12'hccf, 12'h448, 12'hfe6, 12'h553, 12'h331},
        '{12'h358, 12'h222, 12'h8ab, 12'h567, 12'heff, 12'h235, 12'hff9, 12'h234, 12'h112},
        '{12'h6a4, 12'h353, 12'hbb8, 12'h885, 12'hffd, 12'h341, 12'hfd5, 12'h762, 12'h431},
        '{12'h747, 12'h303, 12'hdad, 12'h979, 12'hfcf, 12'h526, 12'hf8f, 12'h425, 12'h213}
    };

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        hsync;
        logic        vblnk;
        logic        hblnk;
    } vga_timing_t;

    localparam int VGA_TIMING_W = $bits(vga_timing_t);

    typedef enum logic [3:0] {
        ClrBlack,
        ClrWall,
        ClrMortar,
        ClrColBase,
        ClrColDark,
        ClrWinHi,
        ClrWinLo,
        ClrWinGlow,
        ClrFloorBase,
        ClrFloorDark
    } bg_colour_e;

    // Window centres are spread evenly across the gap between two columns.
    function automatic int win_centre(int col_w, int col_pitch, int num_windows, int idx);
        if (num_windows <= 0) return 0;
        return col_w + ((col_pitch - col_w) * (2 * idx + 1)) / (2 * num_windows);
    endfunction

    function automatic logic [11:0] palette_pick(palette_t pal, bg_colour_e cls);
        logic [11:0] rgb;
        rgb = 12'h000;
        case (cls)
            ClrWall:      rgb = pal.wall_base;
            ClrMortar:    rgb = pal.mortar;
            ClrColBase:   rgb = pal.col_base;
            ClrColDark:   rgb = pal.col_dark;
            ClrWinHi:     rgb = pal.win_hi;
            ClrWinLo:     rgb = pal.win_lo;
            ClrWinGlow:   rgb = pal.win_glow;
            ClrFloorBase: rgb = pal.floor_base;
            ClrFloorDark: rgb = pal.floor_dark;
            default:      rgb = 12'h000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle.
// in : consumer view (all fields are inputs)
// out: producer view (all fields are outputs)
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// Fixed-length delay line for the packed VGA timing bundle.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears every stage
//   din  - timing bundle in (bg_pkg::vga_timing_t packed)
//   dout - timing bundle DELAY cycles later
module vga_delay
    import bg_pkg::*;
#(
    parameter int DELAY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [VGA_TIMING_W-1:0] din,
    output logic [VGA_TIMING_W-1:0] dout
);

    logic [VGA_TIMING_W-1:0] pipe_q [DELAY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/draw_bg_scroll.sv
// Scrolling brick-wall background with columns, windows and a floor.
// Ports:
//   clk, rst     - clock; asynchronous active-high reset
//   vga_in       - incoming timing (rgb ignored)
//   vga_out      - timing delayed 3 cycles plus background rgb
//   scroll_x_in  - requested world x offset, latched by scroll_we
//   theme_in     - requested palette theme, latched by theme_we
// Requests sit in pending registers and only become active on a vblnk
// rising edge so a frame never tears.
module draw_bg_scroll
    import bg_pkg::*;
#(
    parameter int FLOOR_Y     = 500,
    parameter int TILE_LOG2   = 4,
    parameter int COL_PITCH   = 256,
    parameter int COL_W       = 32,
    parameter int NUM_WINDOWS = 2
) (
    input  logic        clk,
    input  logic        rst,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic [10:0] scroll_x_in,
    input  logic        scroll_we,
    input  logic [1:0]  theme_in,
    input  logic        theme_we
);

    localparam int WIN_TOP  = FLOOR_Y / 3;
    localparam int WIN_HALF = 32;
    localparam int WIN_H    = 96;
    localparam int WIN_HI_H = 20;

    // ---------------- frame-synchronous control ----------------
    logic        vblnk_prev_q;
    logic        vblnk_rise;
    logic [10:0] pending_scroll_q, pending_scroll_d;
    logic [1:0]  pending_theme_q, pending_theme_d;
    logic [10:0] active_scroll_q;
    logic [1:0]  active_theme_q;
    logic [7:0]  frame_cnt_q;

    assign vblnk_rise       = vga_in.vblnk & ~vblnk_prev_q;
    // A strobe coinciding with the rise is forwarded straight to active.
    assign pending_scroll_d = scroll_we ? scroll_x_in : pending_scroll_q;
    assign pending_theme_d  = theme_we ? theme_in : pending_theme_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev_q     <= 1'b0;
            pending_scroll_q <= '0;
            pending_theme_q  <= '0;
            active_scroll_q  <= '0;
            active_theme_q   <= '0;
            frame_cnt_q      <= '0;
        end else begin
            vblnk_prev_q     <= vga_in.vblnk;
            pending_scroll_q <= pending_scroll_d;
            pending_theme_q  <= pending_theme_d;
            if (vblnk_rise) begin
                active_scroll_q <= pending_scroll_d;
                active_theme_q  <= pending_theme_d;
                frame_cnt_q     <= frame_cnt_q + 8'd1;
            end
        end
    end

    // ---------------- stage 1: world coordinates ----------------
    // Theme and glow are captured with the pixel so in-flight pixels keep
    // the frame's values even if the active registers change behind them.
    logic [10:0] s1_wx_q;
    logic [10:0] s1_y_q;
    logic        s1_blank_q;
    logic        s1_glow_q;
    logic        s1_valid_q;
    logic [1:0]  s1_theme_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_wx_q    <= '0;
            s1_y_q     <= '0;
            s1_blank_q <= 1'b0;
            s1_glow_q  <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_theme_q <= '0;
        end else begin
            s1_wx_q    <= vga_in.hcount + active_scroll_q;
            s1_y_q     <= vga_in.vcount;
            s1_blank_q <= vga_in.hblnk | vga_in.vblnk;
            s1_glow_q  <= frame_cnt_q[3];
            s1_valid_q <= 1'b1;
            s1_theme_q <= active_theme_q;
        end
    end

    // ---------------- stage 2: region classification ----------------
    logic [10:0]        px;
    logic [TILE_LOG2:0] xm;
    logic               in_col;
    logic               in_win;
    logic               mortar;
    bg_colour_e         s2_cls_d, s2_cls_q;
    logic [1:0]         s2_theme_q;

    always_comb begin
        px     = s1_wx_q & 11'(COL_PITCH - 1);
        in_col = int'(px) < COL_W;
        in_win = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k < NUM_WINDOWS &&
                int'(px) >= win_centre(COL_W, COL_PITCH, NUM_WINDOWS, k) - WIN_HALF &&
                int'(px) <= win_centre(COL_W, COL_PITCH, NUM_WINDOWS, k) + WIN_HALF) begin
                in_win = 1'b1;
            end
        end
        in_win = in_win && int'(s1_y_q) > WIN_TOP && int'(s1_y_q) < WIN_TOP + WIN_H;

        // Odd brick rows shift by half a tile; x mod 2T lives in the low bits.
        xm = s1_wx_q[TILE_LOG2:0] +
             (s1_y_q[TILE_LOG2] ? {1'b0, 1'b1, {(TILE_LOG2-1){1'b0}}} : '0);
        // Upper bits all-zero => (x mod 2T) < 2; all-one => > 2T-3.
        mortar = (xm[TILE_LOG2:1] == '0) || (xm[TILE_LOG2:1] == '1) ||
                 (s1_y_q[TILE_LOG2-1:1] == '0);

        s2_cls_d = ClrBlack;
        if (!s1_valid_q || s1_blank_q) begin
            s2_cls_d = ClrBlack;
        end else if (int'(s1_y_q) >= FLOOR_Y) begin
            s2_cls_d = (s1_y_q[2:1] == 2'b00) ? ClrFloorDark : ClrFloorBase;
        end else if (in_col) begin
            s2_cls_d = (s1_wx_q[1:0] == 2'b01) ? ClrColDark : ClrColBase;
        end else if (in_win) begin
            if (int'(s1_y_q) < WIN_TOP + WIN_HI_H) s2_cls_d = ClrWinHi;
            else                                  s2_cls_d = s1_glow_q ? ClrWinGlow : ClrWinLo;
        end else if (mortar) begin
            s2_cls_d = ClrMortar;
        end else begin
            s2_cls_d = ClrWall;
        end
    end

    // ---------------- stages 2/3 registers ----------------
    logic [11:0] rgb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_cls_q   <= ClrBlack;
            s2_theme_q <= '0;
            rgb_q      <= '0;
        end else begin
            s2_cls_q   <= s2_cls_d;
            s2_theme_q <= s1_theme_q;
            rgb_q      <= palette_pick(THEME_PALETTE[s2_theme_q], s2_cls_q);
        end
    end

    // ---------------- timing delay line ----------------
    vga_timing_t dly_in, dly_out;

    assign dly_in.vcount = vga_in.vcount;
    assign dly_in.hcount = vga_in.hcount;
    assign dly_in.vsync  = vga_in.vsync;
    assign dly_in.hsync  = vga_in.hsync;
    assign dly_in.vblnk  = vga_in.vblnk;
    assign dly_in.hblnk  = vga_in.hblnk;

    vga_delay #(
        .DELAY(3)
    ) u_vga_delay (
        .clk (clk),
        .rst (rst),
        .din (dly_in),
        .dout(dly_out)
    );

    assign vga_out.vcount = dly_out.vcount;
    assign vga_out.hcount = dly_out.hcount;
    assign vga_out.vsync  = dly_out.vsync;
    assign vga_out.hsync  = dly_out.hsync;
    assign vga_out.vblnk  = dly_out.vblnk;
    assign vga_out.hblnk  = dly_out.hblnk;
    assign vga_out.rgb    = rgb_q;

    // Incoming colour is deliberately discarded.
    logic unused_rgb;
    assign unused_rgb = ^vga_in.rgb;

endmodule

// File: tb/tb_draw_bg_scroll.sv
module tb_draw_bg_scroll;

    // Theme table: wall, mortar, col_base, col_dark, win_hi, win_lo, win_glow,
    // floor_base, floor_dark
    localparam logic [11:0] PAL [4][9] = '{
        '{12'h833, 12'h444, 12'h999, 12'h666, 12'hccf, 12'h448, 12'hfe6, 12'h553, 12'h331},
        '{12'h358, 12'h222, 12'h8ab, 12'h567, 12'heff, 12'h235, 12'hff9, 12'h234, 12'h112},
        '{12'h6a4, 12'h353, 12'hbb8, 12'h885, 12'hffd, 12'h341, 12'hfd5, 12'h762, 12'h431},
        '{12'h747, 12'h303, 12'hdad, 12'h979, 12'hfcf, 12'h526, 12'hf8f, 12'h425, 12'h213}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] scroll_x_in;
    logic        scroll_we;
    logic [1:0]  theme_in;
    logic        theme_we;

    vga_if vin ();
    vga_if vout ();

    draw_bg_scroll dut (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (vin),
        .vga_out    (vout),
        .scroll_x_in(scroll_x_in),
        .scroll_we  (scroll_we),
        .theme_in   (theme_in),
        .theme_we   (theme_we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic [25:0] tim;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // reference model state
    int m_pend_scroll, m_pend_theme, m_act_scroll, m_act_theme, m_frames;
    bit m_prev_vb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_rgb(int h, int v, bit hb, bit vb,
                                            int scroll, int theme, int frames);
        int wx, px, xp, c;
        bit in_win;
        if (hb || vb) return 12'h000;
        wx = (h + scroll) % 2048;
        if (v >= 500) return (v % 8 < 2) ? PAL[theme][8] : PAL[theme][7];
        px = wx % 256;
        if (px < 32) return (wx % 4 == 1) ? PAL[theme][3] : PAL[theme][2];
        // two windows centred in the 224-pixel gap after each column
        in_win = 0;
        for (int k = 0; k < 2; k++) begin
            c = 32 + (224 * (2 * k + 1)) / 4;
            if (px >= c - 32 && px <= c + 32) in_win = 1;
        end
        if (in_win && v > 166 && v < 262) begin
            if (v < 186) return PAL[theme][4];
            return ((frames % 16) >= 8) ? PAL[theme][6] : PAL[theme][5];
        end
        xp = ((v / 16) % 2 == 1) ? wx + 8 : wx;
        if (xp % 32 < 2 || xp % 32 > 29 || v % 16 < 2) return PAL[theme][1];
        return PAL[theme][0];
    endfunction

    // Drive one pixel (called at posedge+1), queue its expected output.
    task automatic step(input int h, input int v, input bit hs, input bit hb, input bit vb,
                        input bit swe, input int sx, input bit twe, input int th);
        exp_t e;
        vin.hcount  = 11'(h);
        vin.vcount  = 11'(v);
        vin.hsync   = hs;
        vin.vsync   = vb;
        vin.hblnk   = hb;
        vin.vblnk   = vb;
        vin.rgb     = 12'($urandom);
        scroll_we   = swe;
        scroll_x_in = 11'(sx);
        theme_we    = twe;
        theme_in    = 2'(th);
        e.due = cyc + 3;
        e.rgb = ref_rgb(h, v, hb, vb, m_act_scroll, m_act_theme, m_frames);
        e.tim = {11'(v), 11'(h), vb, hs, vb, hb};
        sb.push_back(e);
        if (swe) m_pend_scroll = sx;
        if (twe) m_pend_theme = th;
        if (vb && !m_prev_vb) begin
            m_act_scroll = m_pend_scroll;
            m_act_theme  = m_pend_theme;
            m_frames++;
        end
        m_prev_vb = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v);
        step(h, v, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 2047), $urandom_range(0, 640), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0, 0, 0, 0, 0, 0);
    endtask

    task automatic vblank(input int len);
        for (int i = 0; i < len; i++) step(0, 600 + i, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_pend_scroll = 0;
        m_pend_theme  = 0;
        m_act_scroll  = 0;
        m_act_theme   = 0;
        m_frames      = 0;
        m_prev_vb     = 0;
    endtask

    // Release at posedge+1; the two following output cycles must stay zero.
    task automatic release_reset();
        exp_t z;
        rst   = 1'b0;
        z.rgb = '0;
        z.tim = '0;
        z.due = cyc + 1;
        sb.push_back(z);
        z.due = cyc + 2;
        sb.push_back(z);
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_rgb"}, 32'(vout.rgb), 32'h0);
        chk({name, "_timing"}, 32'({vout.vcount, vout.hcount, vout.vsync, vout.hsync,
                                   vout.vblnk, vout.hblnk}), 32'h0);
    endtask

    // Scoreboard monitor: samples on the falling edge.
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            if (sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                chk("missed_slot", 32'(cyc), 32'(mon_e.due));
            end else if (sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("rgb", 32'(vout.rgb), 32'(mon_e.rgb));
                chk("timing", 32'({vout.vcount, vout.hcount, vout.vsync, vout.hsync,
                                   vout.vblnk, vout.hblnk}), 32'(mon_e.tim));
            end
        end
    end

    initial begin
        bit vb;
        rst = 1'b1;
        model_reset();
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 0; vin.vsync = 0;
        vin.hblnk = 0; vin.vblnk = 0; vin.rgb = 12'hfff;
        scroll_x_in = '0; scroll_we = 0; theme_in = '0; theme_we = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_hold");
        release_reset();

        // first pixel after reset: world x 0 is inside a column
        pix(0, 0);
        pix(33, 0);
        pix(40, 17);
        pix(1, 100);
        rand_pixels(40);
        vblank(2);
        rand_pixels(20);

        // scroll request mid-frame: rest of frame must stay unshifted
        step(300, 200, 0, 0, 0, 1, 100, 0, 0);
        rand_pixels(20);
        pix(0, 300);
        vblank(2);
        pix(0, 300);
        pix(0, 17);
        pix(50, 499);
        pix(50, 500);
        pix(50, 502);

        // scroll 2040 + theme 2 written on the very rising cycle
        step(0, 600, 0, 1, 1, 1, 2040, 1, 2);
        vblank(1);
        pix(10, 300);
        pix(9, 300);
        pix(10, 520);
        rand_pixels(20);

        // horizontal blanking with toggling hsync
        for (int i = 0; i < 8; i++) step(800 + i, 100, i % 2, 1, 0, 0, 0, 0, 0);

        // back to scroll 0, theme 3
        step(0, 10, 0, 0, 0, 1, 0, 1, 3);
        vblank(2);
        // window edges and glow over 16 frames
        for (int f = 0; f < 16; f++) begin
            pix(100, 220);
            pix(100, 170);
            pix(56, 220);
            pix(55, 220);
            pix(120, 230);
            pix(121, 230);
            pix(200, 166);
            pix(200, 261);
            vblank(1);
        end

        // 256 short frames: glow phase must be back where it was
        for (int f = 0; f < 256; f++) begin
            pix(100, 220);
            vblank(1);
        end
        for (int f = 0; f < 10; f++) begin
            pix(100, 220);
            vblank(1);
        end

        // random mix with strobes that may coincide with vblnk rises
        for (int i = 0; i < 300; i++) begin
            vb = ($urandom_range(0, 11) == 0);
            step($urandom_range(0, 2047), vb ? 600 : $urandom_range(0, 640),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, vb,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2047),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3));
        end

        // non-zero active and pending state, then reset between edges
        step(0, 10, 0, 0, 0, 1, 777, 1, 1);
        vblank(2);
        pix(0, 300);
        step(5, 300, 0, 0, 0, 1, 55, 1, 2);
        pix(6, 300);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        sb.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        release_reset();
        pix(0, 300);
        pix(40, 300);
        vblank(2);
        pix(0, 300);
        pix(40, 300);
        rand_pixels(20);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_left", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_bg_scroll.md
DRAW_BG_SCROLL -- requirements
Module: draw_bg_scroll

Interface
REQ-001 Parameter FLOOR_Y, default 500: first floor line in screen coordinates.
REQ-002 Parameter TILE_LOG2, default 4, legal 3..5: brick tile size is 2**TILE_LOG2 pixels.
REQ-003 Parameter COL_PITCH, default 256, a power of two from 64 to 1024: column spacing in world x.
REQ-004 Parameter COL_W, default 32, less than COL_PITCH: column width.
REQ-005 Parameter NUM_WINDOWS, default 2, legal 0..4: windows per COL_PITCH span, centred between columns.
REQ-006 Port clk, input, 1 bit: the single clock.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port vga_in, vga_if.in: timing input (vcount, hcount, vsync, hsync, vblnk, hblnk); rgb is ignored.
REQ-009 Port vga_out, vga_if.out: timing outputs plus background rgb.
REQ-010 Port scroll_x_in, input, 11 bits: requested horizontal world offset.
REQ-011 Port scroll_we, input, 1 bit: write strobe for the scroll request.
REQ-012 Port theme_in, input, 2 bits: requested palette theme.
REQ-013 Port theme_we, input, 1 bit: write strobe for the theme request.

Function
REQ-014 The module SHALL delay every vga_out timing signal by exactly 3 clk cycles relative to vga_in, with rgb aligned to that same pixel.
REQ-015 scroll_we SHALL load pending_scroll; theme_we SHALL load pending_theme.
REQ-016 On the cycle vga_in.vblnk rises (0 to 1), the module SHALL copy pending values into active_scroll and active_theme.
REQ-017 If a write strobe coincides with the vblnk rising edge, the newly written value SHALL become active on that same edge.
REQ-018 Active values SHALL NOT change at any time other than a vblnk rising edge, so a frame never tears.
REQ-019 An 8-bit frame_cnt SHALL increment on each vblnk rising edge and wrap from 255 to 0.
REQ-020 World x SHALL be (hcount + active_scroll) mod 2048, computed at 11-bit width with carry discarded; y SHALL be vcount, unscrolled.
REQ-021 When hblnk or vblnk is set, rgb SHALL be 12'h000.
REQ-022 When y >= FLOOR_Y, rgb SHALL be floor_dark[theme] if (y mod 8) < 2, otherwise floor_base[theme].
REQ-023 When y < FLOOR_Y, colour SHALL be selected by this priority, highest first:
- column: (world x mod COL_PITCH) < COL_W; rgb = col_dark if (world x mod 4) == 1, otherwise col_base.
- window: world x within ±32 of a window centre and FLOOR_Y/3 < y < FLOOR_Y/3 + 96; rgb = win_hi if y < FLOOR_Y/3 + 20, otherwise win_lo. When frame_cnt[3] == 1, win_lo SHALL be replaced by win_glow.
- mortar: with T = 2**TILE_LOG2 and row = y >> TILE_LOG2, let x' = world x + T/2 when row is odd, otherwise world x. Mortar when (x' mod 2T) < 2, or (x' mod 2T) > 2T-3, or (y mod T) < 2.
- otherwise: wall_base.
REQ-024 All colours in REQ-022 and REQ-023 SHALL be indexed by active_theme.
REQ-025 NUM_WINDOWS = 0 SHALL suppress all windows.

Reset
REQ-026 While rst is high, all vga_out fields, the pipeline registers, pending and active scroll/theme, and frame_cnt SHALL be 0, immediately and without waiting for a clock edge.
REQ-027 The first valid pixel SHALL appear 3 cycles after rst deasserts; outputs in between SHALL remain 0.

Structure
REQ-028 The palette typedef (struct of 12-bit colours) and the 4-entry theme palette constant SHALL live in a shared package, bg_pkg.
REQ-029 The 3-stage timing delay line SHALL be a sub-module, vga_delay, with a DELAY parameter, reusable by other draw blocks.

Verification
REQ-030 Release reset with scroll 0, theme 0 and pixel h=0, v=0 unblanked; 3 cycles later rgb SHALL equal the theme-0 mortar colour 12'h444, or col_base if a column occupies world x 0.
REQ-031 Write scroll_x_in=100 mid-frame; remaining lines SHALL be unshifted, and after the next vblnk rise pixel h=0 SHALL show world x 100.
REQ-032 Write scroll_x_in=2040 and apply it; hcount=10 SHALL render world x 2, confirming wrap.
REQ-033 Drive hblnk=1 with toggling hsync; rgb SHALL be 12'h000 and hsync SHALL be a 3-cycle delayed copy of the input.
REQ-034 Run 16 frames; window lower pixels SHALL read win_lo for frames 0-7 and win_glow for frames 8-15; frame_cnt SHALL wrap from 255 to 0 after 256 frames.
REQ-035 Assert rst mid-line between clock edges; all outputs SHALL be 0 immediately; after release, scroll and theme SHALL be 0.
